// File: rtl/mem_access_unit.sv
// Load/store unit bridging the pipeline to a single-beat data bus.
// Handles lane steering, sign extension, misalignment and bus-timeout exceptions.
module mem_access_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BIG_ENDIAN = 1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                cpu_clk_50M,
  input  logic                cpu_rst,
  input  logic                op_valid,
  input  logic [2:0]          op_type,
  input  logic [ADDR_W-1:0]   op_addr,
  input  logic [31:0]         op_wdata,
  input  logic                flush,
  output logic                stall_o,
  output logic                ld_valid,
  output logic [31:0]         ld_data,
  output logic                exc_valid,
  output logic [4:0]          exc_code,
  output logic [ADDR_W-1:0]   exc_badvaddr,
  output logic                dbus_req,
  output logic                dbus_we,
  output logic [DATA_W/8-1:0] dbus_be,
  output logic [ADDR_W-1:0]   dbus_addr,
  output logic [DATA_W-1:0]   dbus_wdata,
  input  logic                dbus_ack,
  input  logic [DATA_W-1:0]   dbus_rdata
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_next;

  logic [2:0]        r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rdata;
  logic [7:0]        r_cnt;
  logic              r_cancel, r_exc;
  logic [4:0]        r_exc_code;
  logic              r_dbus_req, r_dbus_we;
  logic [NB-1:0]     r_dbus_be;
  logic [ADDR_W-1:0] r_dbus_addr;
  logic [DATA_W-1:0] r_dbus_wdata;

  logic              w_accept, w_is_load, w_misal, w_ack, w_timeout;
  logic [2:0]        w_size, w_rsize;
  logic [OFS_W-1:0]  w_k, w_rk;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [7:0]        w_byte;
  logic [31:0]       w_raw, w_ld;

  function automatic logic [2:0] f_size(input logic [2:0] t);
    case (t)
      3'b000, 3'b001, 3'b101: f_size = 3'd1;
      3'b010, 3'b011, 3'b110: f_size = 3'd2;
      default:                f_size = 3'd4;
    endcase
  endfunction

  // Physical byte slot (data bits [8p+7:8p]) holding bus lane 'lane'.
  function automatic int unsigned f_pos(input int unsigned lane);
    f_pos = (BIG_ENDIAN != 0) ? (NB - 1 - (lane % NB)) : (lane % NB);
  endfunction

  assign w_size    = f_size(op_type);
  assign w_rsize   = f_size(r_type);
  assign w_k       = op_addr[OFS_W-1:0];
  assign w_rk      = r_addr[OFS_W-1:0];
  assign w_is_load = (op_type <= 3'b100);
  assign w_misal   = ((w_size == 3'd2) && op_addr[0]) ||
                     ((w_size == 3'd4) && (op_addr[1:0] != 2'b00));
  assign w_ack     = dbus_ack & r_dbus_req;
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_be = '0;
    for (int unsigned i = 0; i < NB; i++)
      if ((i >= 32'(w_k)) && (i < 32'(w_k) + 32'(w_size))) w_be[f_pos(i)] = 1'b1;
  end

  // Aligned lanes make plain replication correct for either byte order.
  always_comb begin
    case (w_size)
      3'd1:    w_wdata = {NB{op_wdata[7:0]}};
      3'd2:    w_wdata = {(NB/2){op_wdata[15:0]}};
      default: w_wdata = {(NB/4){op_wdata}};
    endcase
    if (w_is_load) w_wdata = '0;
  end

  always_comb begin
    w_raw  = '0;
    w_byte = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < 32'(w_rsize)) begin
        w_byte = r_rdata[8*f_pos(32'(w_rk) + i) +: 8];
        if (BIG_ENDIAN != 0) w_raw = {w_raw[23:0], w_byte};
        else                 w_raw[8*i +: 8] = w_byte;
      end
    end
    case (r_type)
      3'b000:  w_ld = {{24{w_raw[7]}}, w_raw[7:0]};
      3'b001:  w_ld = {24'h0, w_raw[7:0]};
      3'b010:  w_ld = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b011:  w_ld = {16'h0, w_raw[15:0]};
      default: w_ld = w_raw;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    stall_o      = 1'b0;
    ld_valid     = 1'b0;
    ld_data      = '0;
    exc_valid    = 1'b0;
    exc_code     = '0;
    exc_badvaddr = '0;
    case (r_state)
      S_IDLE: begin
        if (op_valid && !flush) begin
          w_accept = 1'b1;
          stall_o  = 1'b1;
          w_next   = w_misal ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        stall_o = 1'b1;
        if (w_ack || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
        if (!r_cancel && !flush) begin
          if (r_exc) begin
            exc_valid    = 1'b1;
            exc_code     = r_exc_code;
            exc_badvaddr = r_addr;
          end else if (r_type <= 3'b100) begin
            ld_valid = 1'b1;
            ld_data  = w_ld;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_type       <= '0;
      r_addr       <= '0;
      r_rdata      <= '0;
      r_cnt        <= '0;
      r_cancel     <= 1'b0;
      r_exc        <= 1'b0;
      r_exc_code   <= '0;
      r_dbus_req   <= 1'b0;
      r_dbus_we    <= 1'b0;
      r_dbus_be    <= '0;
      r_dbus_addr  <= '0;
      r_dbus_wdata <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_type     <= op_type;
        r_addr     <= op_addr;
        r_cnt      <= '0;
        r_cancel   <= 1'b0;
        r_exc      <= w_misal;
        r_exc_code <= w_is_load ? 5'h04 : 5'h05;
        if (!w_misal) begin
          r_dbus_req   <= 1'b1;
          r_dbus_we    <= !w_is_load;
          r_dbus_be    <= w_be;
          r_dbus_addr  <= op_addr & ~ADDR_W'(NB - 1);
          r_dbus_wdata <= w_wdata;
        end
      end
    end else if (r_state == S_BUSY) begin
      r_cancel <= r_cancel | flush;
      if (w_ack || w_timeout) begin
        r_dbus_req   <= 1'b0;
        r_dbus_we    <= 1'b0;
        r_dbus_be    <= '0;
        r_dbus_addr  <= '0;
        r_dbus_wdata <= '0;
        if (w_ack) begin
          r_rdata <= dbus_rdata;
        end else begin
          r_exc      <= 1'b1;
          r_exc_code <= 5'h07;
        end
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign dbus_req   = r_dbus_req;
  assign dbus_we    = r_dbus_we;
  assign dbus_be    = r_dbus_be;
  assign dbus_addr  = r_dbus_addr;
  assign dbus_wdata = r_dbus_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a 32-bit big-endian and a 64-bit little-endian
// instance run the same op stream in lockstep against a byte-level reference model.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_rst, op_valid, flush, dbus_ack;
  logic [2:0]  op_type;
  logic [31:0] op_addr, op_wdata;
  logic [63:0] rdata;

  logic        a_stall, a_ldv, a_exv, a_req, a_we;
  logic [31:0] a_ld, a_bad, a_addr, a_wd;
  logic [4:0]  a_code;
  logic [3:0]  a_be;
  logic        b_stall, b_ldv, b_exv, b_req, b_we;
  logic [31:0] b_ld, b_bad, b_addr;
  logic [63:0] b_wd;
  logic [4:0]  b_code;
  logic [7:0]  b_be;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT(TO)) u_dut_a (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .op_valid(op_valid), .op_type(op_type),
    .op_addr(op_addr), .op_wdata(op_wdata), .flush(flush), .stall_o(a_stall),
    .ld_valid(a_ldv), .ld_data(a_ld), .exc_valid(a_exv), .exc_code(a_code),
    .exc_badvaddr(a_bad), .dbus_req(a_req), .dbus_we(a_we), .dbus_be(a_be),
    .dbus_addr(a_addr), .dbus_wdata(a_wd), .dbus_ack(dbus_ack), .dbus_rdata(rdata[31:0]));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(0), .TIMEOUT(TO)) u_dut_b (
    .cpu_clk_50M(clk), .cpu_rst(cpu_rst), .op_valid(op_valid), .op_type(op_type),
    .op_addr(op_addr), .op_wdata(op_wdata), .flush(flush), .stall_o(b_stall),
    .ld_valid(b_ldv), .ld_data(b_ld), .exc_valid(b_exv), .exc_code(b_code),
    .exc_badvaddr(b_bad), .dbus_req(b_req), .dbus_we(b_we), .dbus_be(b_be),
    .dbus_addr(b_addr), .dbus_wdata(b_wd), .dbus_ack(dbus_ack), .dbus_rdata(rdata));

  logic [1:0]  stall_v, ldv_v, exv_v, req_v, we_v;
  logic [31:0] ld_v [2];
  logic [31:0] bad_v [2];
  logic [31:0] addr_v [2];
  logic [4:0]  code_v [2];
  logic [7:0]  be_v [2];
  logic [63:0] wd_v [2];
  assign stall_v = {b_stall, a_stall};
  assign ldv_v   = {b_ldv, a_ldv};
  assign exv_v   = {b_exv, a_exv};
  assign req_v   = {b_req, a_req};
  assign we_v    = {b_we, a_we};
  assign ld_v[0] = a_ld;   assign ld_v[1] = b_ld;
  assign bad_v[0] = a_bad; assign bad_v[1] = b_bad;
  assign addr_v[0] = a_addr; assign addr_v[1] = b_addr;
  assign code_v[0] = a_code; assign code_v[1] = b_code;
  assign be_v[0] = {4'h0, a_be}; assign be_v[1] = b_be;
  assign wd_v[0] = {32'h0, a_wd}; assign wd_v[1] = b_wd;

  int tests_run = 0;
  int fails = 0;

  logic [7:0]  last_be [2];
  logic [63:0] last_wd [2];
  logic [31:0] last_addr [2];
  logic        last_we [2];
  logic        last_ldv [2];
  logic        last_exv [2];
  logic [31:0] last_ld [2];
  logic [4:0]  last_code [2];
  logic [31:0] last_bad [2];

  // ---------------- reference model (d=0: 32-bit BE, d=1: 64-bit LE) ----------------
  function automatic int m_size(input logic [2:0] t);
    if (t == 3'd0 || t == 3'd1 || t == 3'd5) return 1;
    if (t == 3'd2 || t == 3'd3 || t == 3'd6) return 2;
    return 4;
  endfunction

  function automatic int m_nb(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  // bit offset of the byte at bus-relative address j
  function automatic int m_bit(input int d, input int j);
    return (d == 0) ? (32 - 8 - 8 * j) : (8 * j);
  endfunction

  function automatic int m_ofs(input int d, input logic [31:0] a);
    return int'(a % 32'(m_nb(d)));
  endfunction

  function automatic logic [7:0] m_be(input int d, input logic [2:0] t, input logic [31:0] a);
    logic [7:0] be;
    int k;
    be = '0;
    k = m_ofs(d, a);
    for (int j = k; j < k + m_size(t); j++) be[m_bit(d, j) / 8] = 1'b1;
    return be;
  endfunction

  function automatic logic [63:0] m_wdata(input int d, input logic [2:0] t, input logic [31:0] wd);
    logic [63:0] w;
    logic [7:0]  b;
    int n, u;
    w = '0;
    n = m_size(t);
    if (t <= 3'd4) return '0;
    for (int j = 0; j < m_nb(d); j++) begin
      u = j % n;
      b = (d == 0) ? 8'(wd >> (8 * (n - 1 - u))) : 8'(wd >> (8 * u));
      w = w | (64'(b) << m_bit(d, j));
    end
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int d, input logic [2:0] t, input logic [31:0] a,
                                         input logic [63:0] rd);
    logic [31:0] v;
    logic [7:0]  b;
    int k;
    v = '0;
    k = m_ofs(d, a);
    for (int i = 0; i < m_size(t); i++) begin
      b = 8'(rd >> m_bit(d, k + i));
      if (d == 0) v = (v << 8) | 32'(b);
      else        v = v | (32'(b) << (8 * i));
    end
    if (t == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (t == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // One full operation: accept, BUSY (ack at ack_at, flush at flush_at), DONE.
  task automatic run_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input int flush_at, input bit flush_done,
                        input logic [63:0] rd);
    bit ld, mis, acked, cancel, exv, ldv;
    logic [4:0]  code;
    logic [31:0] exp_ld;
    ld = (t <= 3'd4);
    mis = (a % 32'(m_size(t))) != 0;
    acked = 0;
    cancel = 0;
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = t; op_addr = a; op_wdata = wd; flush = 1'b0; dbus_ack = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if ({stall_v[d], req_v[d]} !== 2'b10) begin
        fails++;
        $display("FAIL accept dut%0d: stall,req=%b want 10", d, {stall_v[d], req_v[d]});
      end
    end
    if (!mis) begin
      for (int c = 0; c < TO; c++) begin
        @(posedge clk); #1;
        op_valid = 1'b0;
        dbus_ack = (c == ack_at);
        flush = (c == flush_at);
        rdata = dbus_ack ? rd : {$urandom, $urandom};
        if (flush) cancel = 1;
        #1;
        for (int d = 0; d < 2; d++) begin
          last_be[d] = be_v[d]; last_wd[d] = wd_v[d]; last_addr[d] = addr_v[d]; last_we[d] = we_v[d];
          tests_run++;
          if ({req_v[d], stall_v[d], ldv_v[d], exv_v[d]} !== 4'b1100) begin
            fails++;
            $display("FAIL busy_ctl dut%0d c%0d: req,stall,ldv,exv=%b want 1100", d, c,
                     {req_v[d], stall_v[d], ldv_v[d], exv_v[d]});
          end
          tests_run++;
          if ({we_v[d], be_v[d], addr_v[d], wd_v[d]} !==
              {!ld, m_be(d, t, a), a & ~32'(m_nb(d) - 1), m_wdata(d, t, wd)}) begin
            fails++;
            $display("FAIL busy_bus dut%0d c%0d: we=%b be=%h addr=%h wd=%h want we=%b be=%h addr=%h wd=%h",
                     d, c, we_v[d], be_v[d], addr_v[d], wd_v[d], !ld, m_be(d, t, a),
                     a & ~32'(m_nb(d) - 1), m_wdata(d, t, wd));
          end
        end
        if (dbus_ack) begin
          acked = 1;
          break;
        end
      end
    end
    @(posedge clk); #1;
    op_valid = 1'b0; dbus_ack = 1'b0; flush = flush_done; rdata = {$urandom, $urandom};
    #1;
    exv = !flush_done && !cancel && (mis || !acked);
    ldv = !flush_done && !cancel && !mis && acked && ld;
    code = exv ? (mis ? (ld ? 5'h04 : 5'h05) : 5'h07) : 5'h00;
    for (int d = 0; d < 2; d++) begin
      exp_ld = ldv ? m_load(d, t, a, rd) : 32'h0;
      last_ldv[d] = ldv_v[d]; last_ld[d] = ld_v[d];
      last_exv[d] = exv_v[d]; last_code[d] = code_v[d]; last_bad[d] = bad_v[d];
      tests_run++;
      if ({stall_v[d], req_v[d]} !== 2'b00) begin
        fails++;
        $display("FAIL done_ctl dut%0d: stall,req=%b want 00", d, {stall_v[d], req_v[d]});
      end
      tests_run++;
      if ({ldv_v[d], ld_v[d]} !== {ldv, exp_ld}) begin
        fails++;
        $display("FAIL done_ld dut%0d t=%0d a=%h: ldv=%b data=%h want ldv=%b data=%h",
                 d, t, a, ldv_v[d], ld_v[d], ldv, exp_ld);
      end
      tests_run++;
      if ({exv_v[d], code_v[d], bad_v[d]} !== {exv, code, exv ? a : 32'h0}) begin
        fails++;
        $display("FAIL done_exc dut%0d t=%0d a=%h: exv=%b code=%h bad=%h want exv=%b code=%h bad=%h",
                 d, t, a, exv_v[d], code_v[d], bad_v[d], exv, code, exv ? a : 32'h0);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests_run++;
      if ({stall_v[d], ldv_v[d], exv_v[d], req_v[d], we_v[d], be_v[d], addr_v[d], wd_v[d],
           ld_v[d], code_v[d], bad_v[d]} !== '0) begin
        fails++;
        $display("FAIL reset dut%0d: outputs not all zero (stall=%b req=%b be=%h addr=%h)",
                 d, stall_v[d], req_v[d], be_v[d], addr_v[d]);
      end
    end
    cpu_rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    run_op(3'b000, 32'h1003, 32'h0, 1, -1, 0, 64'h0000_0000_1122_33F0);
    tests_run++;
    if ({last_be[0], last_ldv[0], last_ld[0]} !== {8'h01, 1'b1, 32'hFFFF_FFF0}) begin
      fails++;
      $display("FAIL lb_be_vector: be=%h ldv=%b ld=%h want be=01 ldv=1 ld=fffffff0",
               last_be[0], last_ldv[0], last_ld[0]);
    end
    @(posedge clk); #1;
    tests_run++;
    if (ldv_v !== 2'b00) begin
      fails++;
      $display("FAIL ld_valid_one_cycle: ldv=%b want 00", ldv_v);
    end
    run_op(3'b110, 32'h2006, 32'h0000_ABCD, 0, -1, 0, 64'h0);
    tests_run++;
    if ({last_we[1], last_be[1], last_addr[1], last_wd[1]} !==
        {1'b1, 8'hC0, 32'h2000, 64'hABCD_ABCD_ABCD_ABCD}) begin
      fails++;
      $display("FAIL sh_le64_vector: we=%b be=%h addr=%h wd=%h want we=1 be=c0 addr=2000 wd=abcdabcdabcdabcd",
               last_we[1], last_be[1], last_addr[1], last_wd[1]);
    end
    run_op(3'b100, 32'h3002, 32'h0, 0, -1, 0, 64'h0);
    tests_run++;
    if ({last_exv[0], last_code[0], last_bad[0]} !== {1'b1, 5'h04, 32'h3002}) begin
      fails++;
      $display("FAIL lw_misaligned: exv=%b code=%h bad=%h want 1 04 3002",
               last_exv[0], last_code[0], last_bad[0]);
    end
    run_op(3'b111, 32'h2001, 32'h1234_5678, 0, -1, 0, 64'h0);
    tests_run++;
    if ({last_exv[1], last_code[1]} !== {1'b1, 5'h05}) begin
      fails++;
      $display("FAIL sw_misaligned: exv=%b code=%h want 1 05", last_exv[1], last_code[1]);
    end
  endtask

  task automatic test_timeout();
    run_op(3'b011, 32'h0000_0104, 32'h0, -1, -1, 0, 64'h0);
    tests_run++;
    if ({last_exv[0], last_code[0], last_ldv[0]} !== {1'b1, 5'h07, 1'b0}) begin
      fails++;
      $display("FAIL timeout_exc: exv=%b code=%h ldv=%b want 1 07 0",
               last_exv[0], last_code[0], last_ldv[0]);
    end
    run_op(3'b011, 32'h0000_0106, 32'h0, TO - 1, -1, 0, 64'h8899_AABB_CCDD_EEFF);
    tests_run++;
    if ({last_exv[1], last_ldv[1], last_ld[1]} !== {1'b0, 1'b1, 32'h0000_8899}) begin
      fails++;
      $display("FAIL ack_wins_timeout: exv=%b ldv=%b ld=%h want 0 1 00008899",
               last_exv[1], last_ldv[1], last_ld[1]);
    end
  endtask

  task automatic test_flush();
    run_op(3'b100, 32'h0000_0040, 32'h0, 3, 1, 0, 64'hDEAD_BEEF_0BAD_F00D);
    run_op(3'b010, 32'h0000_0042, 32'h0, 0, -1, 1, 64'h1234_5678_9ABC_DEF0);
    run_op(3'b110, 32'h0000_0041, 32'h0, 0, -1, 1, 64'h0);
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 3'b100; op_addr = 32'h80; flush = 1'b1;
    #1;
    tests_run++;
    if (stall_v !== 2'b00) begin
      fails++;
      $display("FAIL flush_idle_stall: stall=%b want 00", stall_v);
    end
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    #1;
    tests_run++;
    if ({req_v, exv_v, ldv_v, stall_v} !== 8'h00) begin
      fails++;
      $display("FAIL flush_idle_blocked: req=%b exv=%b ldv=%b stall=%b want all 0",
               req_v, exv_v, ldv_v, stall_v);
    end
  endtask

  task automatic test_done_ignores_valid();
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 3'b100; op_addr = 32'h3002;
    @(posedge clk); #1;
    #1;
    tests_run++;
    if ({exv_v, stall_v} !== 4'b1100) begin
      fails++;
      $display("FAIL done_with_valid: exv=%b stall=%b want 11 00", exv_v, stall_v);
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    tests_run++;
    if ({exv_v, req_v} !== 4'b0000) begin
      fails++;
      $display("FAIL done_valid_ignored: exv=%b req=%b want 00 00", exv_v, req_v);
    end
  endtask

  task automatic test_reset_busy();
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 3'b100; op_addr = 32'h100; flush = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    #1;
    tests_run++;
    if (req_v !== 2'b11) begin
      fails++;
      $display("FAIL rst_busy_pre: req=%b want 11", req_v);
    end
    cpu_rst = 1'b1;
    @(posedge clk); #1;
    cpu_rst = 1'b0;
    dbus_ack = 1'b1;
    rdata = {$urandom, $urandom};
    #1;
    tests_run++;
    if ({req_v, stall_v} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_busy_drop: req=%b stall=%b want 00 00", req_v, stall_v);
    end
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    #1;
    tests_run++;
    if ({req_v, stall_v, ldv_v, exv_v} !== 8'h00) begin
      fails++;
      $display("FAIL stray_ack: req=%b stall=%b ldv=%b exv=%b want all 0", req_v, stall_v, ldv_v, exv_v);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'b100, 32'h0000_0010, 32'h0, 0, -1, 0, 64'h0102_0304_0506_0708);
    run_op(3'b101, 32'h0000_0015, 32'h0000_005A, 0, -1, 0, 64'h0);
    run_op(3'b001, 32'h0000_0017, 32'h0, 0, -1, 0, 64'h8182_8384_8586_8788);
    run_op(3'b010, 32'h0000_001E, 32'h0, 2, -1, 0, 64'hF1F2_F3F4_F5F6_F7F8);
  endtask

  task automatic test_random();
    logic [2:0]  t;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      t = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(m_size(t) - 1);
      run_op(t, a, $urandom, int'($urandom_range(0, TO)),
             ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TO - 1)) : -1,
             $urandom_range(0, 7) == 0, {$urandom, $urandom});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_rst = 1'b1; op_valid = 1'b0; flush = 1'b0; dbus_ack = 1'b0;
    op_type = '0; op_addr = '0; op_wdata = '0; rdata = '0;
    test_reset();
    test_spec_vectors();
    test_timeout();
    test_flush();
    test_done_ignores_valid();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
